// File: rtl/nios_system_leds_pio.sv
// Avalon-MM output PIO: DATA register with atomic set/clear, and a per-bit blink
// engine driven by a programmable prescaler. Registered read data and output pins.
module nios_system_leds_pio #(
  parameter int                        WIDTH          = 8,
  parameter logic [WIDTH-1:0]          RESET_VALUE    = '0,
  parameter int                        PRESCALE_WIDTH = 24,
  parameter logic [PRESCALE_WIDTH-1:0] DEFAULT_PERIOD = 24'd12499999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_OUT      = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // Bus protocol: a write is accepted on any edge where chipselect=1 and write_n=0
  // (no wait states); readdata is refreshed from address on every edge.
  logic                      w_wr;
  logic [WIDTH-1:0]          w_wr_bits;
  logic [PRESCALE_WIDTH-1:0] w_wr_period;
  logic [WIDTH-1:0]          w_data_next;
  logic [31:0]               w_rdata;
  logic                      w_unused;

  logic [WIDTH-1:0]          r_data;
  logic [WIDTH-1:0]          r_blink_en;
  logic [PRESCALE_WIDTH-1:0] r_period;
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic                      r_phase;
  logic [WIDTH-1:0]          r_out;
  logic [31:0]               r_rdata;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_bits   = writedata[WIDTH-1:0];
  assign w_wr_period = writedata[PRESCALE_WIDTH-1:0];
  assign w_unused    = ^writedata;

  always_comb begin
    w_data_next = r_data;
    if (w_wr) begin
      case (address)
        ADDR_DATA:     w_data_next = w_wr_bits;
        ADDR_OUTSET:   w_data_next = r_data | w_wr_bits;
        ADDR_OUTCLEAR: w_data_next = r_data & ~w_wr_bits;
        default:       w_data_next = r_data;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:     w_rdata[WIDTH-1:0]          = r_data;
      ADDR_BLINK_EN: w_rdata[WIDTH-1:0]          = r_blink_en;
      ADDR_PERIOD:   w_rdata[PRESCALE_WIDTH-1:0] = r_period;
      ADDR_OUT:      w_rdata[WIDTH-1:0]          = r_out;
      default:       w_rdata                     = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= RESET_VALUE;
      r_blink_en <= '0;
      r_period   <= DEFAULT_PERIOD;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_out      <= RESET_VALUE;
      r_rdata    <= '0;
    end else begin
      r_data <= w_data_next;
      if (w_wr && address == ADDR_BLINK_EN) begin
        r_blink_en <= w_wr_bits;
      end
      // A PERIOD write restarts the blink cycle and wins over a coincident wrap.
      if (w_wr && address == ADDR_PERIOD) begin
        r_period <= w_wr_period;
        r_cnt    <= '0;
        r_phase  <= 1'b0;
      end else if (r_cnt == r_period) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
      end
      r_out   <= r_data & ~(r_blink_en & {WIDTH{r_phase}});
      r_rdata <= w_rdata;
    end
  end

  assign readdata = r_rdata;
  assign out_port = r_out;

endmodule

// File: tb/tb_nios_system_leds_pio.sv
// Directed bench for nios_system_leds_pio: register access, set/clear, blink timing,
// PERIOD-write override and asynchronous reset.
module tb_nios_system_leds_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks;
  int errors;

  localparam logic [31:0] DEF_PERIOD = 32'd12499999;

  nios_system_leds_pio #(
    .WIDTH          (8),
    .RESET_VALUE    (8'h00),
    .PRESCALE_WIDTH (24),
    .DEFAULT_PERIOD (24'd12499999)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  exp_blink [14];
    logic [7:0]  exp_p1    [6];
    logic [7:0]  exp_p0    [4];
    exp_blink = '{8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hFF,
                  8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
    exp_p1    = '{8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'hFF, 8'hFF};
    exp_p0    = '{8'hFF, 8'hF0, 8'hFF, 8'hF0};
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_out_port", {24'h0, out_port}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    do_read(3'd0, rd); check("rst_rd_data", rd, 32'h0);
    do_read(3'd1, rd); check("rst_rd_blink", rd, 32'h0);
    do_read(3'd2, rd); check("rst_rd_period", rd, DEF_PERIOD);
    do_read(3'd3, rd); check("rst_rd_out", rd, 32'h0);

    // DATA write, upper bits dropped
    do_write(3'd0, 32'hFFFF_FFA5);
    check("data_out_lat0", {24'h0, out_port}, 32'h0);
    @(negedge clk);
    check("data_out_lat1", {24'h0, out_port}, 32'hA5);
    do_read(3'd0, rd); check("data_rd", rd, 32'h0000_00A5);

    // OUTSET then OUTCLEAR back to back
    do_write(3'd4, 32'h0A);
    do_write(3'd5, 32'h81);
    check("setclr_out_af", {24'h0, out_port}, 32'hAF);
    @(negedge clk);
    check("setclr_out_2e", {24'h0, out_port}, 32'h2E);
    do_read(3'd0, rd); check("setclr_rd", rd, 32'h2E);

    // blink, PERIOD=3: write edges E0..E2, then sample after E3..E16
    do_write(3'd2, 32'd3);
    do_write(3'd0, 32'hFF);
    do_write(3'd1, 32'h0F);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check($sformatf("blink_p3_%0d", i), {24'h0, out_port}, {24'h0, exp_blink[i]});
    end

    // PERIOD=1 written on the E20 wrap edge, where phase would have gone to 1
    repeat (3) @(negedge clk);
    do_write(3'd2, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("blink_p1_%0d", i), {24'h0, out_port}, {24'h0, exp_p1[i]});
    end

    // PERIOD=0 written on the E30 wrap edge
    repeat (3) @(negedge clk);
    do_write(3'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("blink_p0_%0d", i), {24'h0, out_port}, {24'h0, exp_p0[i]});
    end
    do_read(3'd0, rd); check("rd_data_ff", rd, 32'hFF);
    check("rd_pre_reset_nonzero", {31'h0, readdata != 32'h0}, 32'h1);

    // asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out", {24'h0, out_port}, 32'h0);
    check("async_rst_rd", readdata, 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_static_%0d", i), {24'h0, out_port}, 32'h0);
    end

    // ignored writes
    do_write(3'd6, 32'hFF);
    do_write(3'd7, 32'hFF);
    do_write(3'd3, 32'hFF);
    @(negedge clk);
    check("ign_out", {24'h0, out_port}, 32'h0);
    do_read(3'd0, rd); check("ign_rd_data", rd, 32'h0);
    do_read(3'd1, rd); check("ign_rd_blink", rd, 32'h0);
    do_read(3'd2, rd); check("ign_rd_period", rd, DEF_PERIOD);
    do_read(3'd3, rd); check("ign_rd_out", rd, 32'h0);

    // OUT readback and write-only / reserved reads
    do_write(3'd0, 32'h5A);
    @(negedge clk);
    do_read(3'd3, rd); check("rd_out_5a", rd, 32'h5A);
    for (int a = 4; a < 8; a++) begin
      do_read(3'(a), rd);
      check($sformatf("rd_zero_addr%0d", a), rd, 32'h0);
    end
    check("final_out", {24'h0, out_port}, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
